// File: rtl/regfile_seq_if.sv
// regfile_seq_if: command and register-file port bundle for regfile_seq.
//   cmd_*  : command handshake (valid/ready), opcode, operands
//   rf_rd_*: combinational register-file read port
//   rf_wr_*: register-file write port, commits on the clk edge
//   busy/done/err: status; err qualifies the one-cycle done pulse
// slave  = the sequencer block, master = command source plus register file.
interface regfile_seq_if #(parameter int OP_W = 2);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [OP_W-1:0] cmd_op;
  logic [2:0]      cmd_dst;
  logic [2:0]      cmd_src;
  logic [7:0]      cmd_imm;
  logic [2:0]      rf_rd_sel;
  logic            rf_rd_en;
  logic [7:0]      rf_rd_data;
  logic [2:0]      rf_wr_sel;
  logic            rf_wr_en;
  logic [7:0]      rf_wr_data;
  logic            busy;
  logic            done;
  logic            err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rf_rd_data,
    output cmd_ready, rf_rd_sel, rf_rd_en, rf_wr_sel, rf_wr_en, rf_wr_data,
           busy, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rf_rd_data,
    input  cmd_ready, rf_rd_sel, rf_rd_en, rf_wr_sel, rf_wr_en, rf_wr_data,
           busy, done, err
  );
endinterface

// File: rtl/regfile_seq.sv
// regfile_seq: sequences 8-bit register-file operations for MOV, LDI,
// INC16 and DEC16 (register pairs BC/DE/HL) over a single read port and a
// single write port.
//   clk  : clock, all state changes on posedge
//   rst  : synchronous active-high reset
//   bus  : regfile_seq_if.slave (command handshake, rf read/write ports,
//          busy/done/err status)
// Every output is decoded from the current state, so IDLE (and therefore
// reset) drives all rf_* enables, selects and data to zero.
module regfile_seq #(
  parameter int OP_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_seq_if.slave bus
);

  localparam logic [OP_W-1:0] OP_MOV = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LDI = OP_W'(1);
  localparam logic [OP_W-1:0] OP_INC = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DEC = OP_W'(3);

  typedef enum logic [3:0] {
    IDLE, LDI_WR, MOV_RD, MOV_WR, RD_LO, WR_LO, RD_HI, WR_HI, ERR
  } state_t;

  state_t          state, state_nx;
  logic [OP_W-1:0] op_q;
  logic [2:0]      dst_q, src_q;
  logic [7:0]      imm_q, temp;
  logic            carry;   // carry for INC16, borrow for DEC16
  logic            accept, cmd_bad, is_inc;
  logic [2:0]      lo_sel, hi_sel;

  assign accept = (state == IDLE) && bus.cmd_valid;
  assign is_inc = (op_q == OP_INC);
  // Pair code sits in dst[2:1]; the low byte register has bit 0 set.
  assign lo_sel = {dst_q[2:1], 1'b1};
  assign hi_sel = {dst_q[2:1], 1'b0};

  // Code 110 is the memory operand slot, not a register; pair 11 is SP/AF.
  always_comb begin
    cmd_bad = 1'b0;
    case (bus.cmd_op)
      OP_MOV:         cmd_bad = (bus.cmd_dst == 3'b110) || (bus.cmd_src == 3'b110);
      OP_LDI:         cmd_bad = (bus.cmd_dst == 3'b110);
      OP_INC, OP_DEC: cmd_bad = (bus.cmd_dst[2:1] == 2'b11);
      default:        cmd_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (cmd_bad)                  state_nx = ERR;
          else if (bus.cmd_op == OP_LDI) state_nx = LDI_WR;
          else if (bus.cmd_op == OP_MOV) state_nx = MOV_RD;
          else                           state_nx = RD_LO;
        end
      end
      MOV_RD:  state_nx = MOV_WR;
      RD_LO:   state_nx = WR_LO;
      WR_LO:   state_nx = RD_HI;
      RD_HI:   state_nx = WR_HI;
      LDI_WR, MOV_WR, WR_HI, ERR: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.rf_rd_sel  = 3'd0;
    bus.rf_rd_en   = 1'b0;
    bus.rf_wr_sel  = 3'd0;
    bus.rf_wr_en   = 1'b0;
    bus.rf_wr_data = 8'd0;
    bus.done       = 1'b0;
    bus.err        = 1'b0;
    case (state)
      LDI_WR: begin
        bus.rf_wr_en   = 1'b1;
        bus.rf_wr_sel  = dst_q;
        bus.rf_wr_data = imm_q;
        bus.done       = 1'b1;
      end
      MOV_RD: begin
        bus.rf_rd_en  = 1'b1;
        bus.rf_rd_sel = src_q;
      end
      MOV_WR: begin
        bus.rf_wr_en   = 1'b1;
        bus.rf_wr_sel  = dst_q;
        bus.rf_wr_data = temp;
        bus.done       = 1'b1;
      end
      RD_LO: begin
        bus.rf_rd_en  = 1'b1;
        bus.rf_rd_sel = lo_sel;
      end
      WR_LO: begin
        bus.rf_wr_en   = 1'b1;
        bus.rf_wr_sel  = lo_sel;
        bus.rf_wr_data = is_inc ? temp + 8'd1 : temp - 8'd1;
      end
      RD_HI: begin
        bus.rf_rd_en  = 1'b1;
        bus.rf_rd_sel = hi_sel;
      end
      WR_HI: begin
        bus.rf_wr_en   = 1'b1;
        bus.rf_wr_sel  = hi_sel;
        bus.rf_wr_data = is_inc ? temp + {7'd0, carry} : temp - {7'd0, carry};
        bus.done       = 1'b1;
      end
      ERR: begin
        bus.done = 1'b1;
        bus.err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      dst_q <= 3'd0;
      src_q <= 3'd0;
      imm_q <= 8'd0;
      temp  <= 8'd0;
      carry <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q  <= bus.cmd_op;
        dst_q <= bus.cmd_dst;
        src_q <= bus.cmd_src;
        imm_q <= bus.cmd_imm;
      end
      case (state)
        MOV_RD, RD_LO, RD_HI: temp <= bus.rf_rd_data;
        // Low byte wraps exactly when it was FF (inc) or 00 (dec).
        WR_LO: carry <= is_inc ? (temp == 8'hFF) : (temp == 8'h00);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_seq.sv
module tb_regfile_seq;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  regfile_seq_if #(.OP_W(2)) bus ();

  regfile_seq #(.OP_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Register-file model; ld_* lets the bench preload values directly.
  logic [7:0] rf [8];
  logic       ld_en;
  logic [2:0] ld_sel;
  logic [7:0] ld_val;

  always @(posedge clk) begin
    if (ld_en) rf[ld_sel] <= ld_val;
    else if (bus.rf_wr_en) rf[bus.rf_wr_sel] <= bus.rf_wr_data;
  end
  assign bus.rf_rd_data = bus.rf_rd_en ? rf[bus.rf_rd_sel] : 8'h00;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check the always-true invariants.
  task automatic step();
    @(negedge clk);
    chk("rd_wr_excl", bus.rf_rd_en && bus.rf_wr_en, 0);
    chk("busy_inv", bus.busy, !bus.cmd_ready);
  endtask

  task automatic load(input logic [2:0] sel, input logic [7:0] val);
    ld_en = 1'b1; ld_sel = sel; ld_val = val;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Offer a command for one edge, then scramble the inputs so any late
  // dependence on cmd_* shows up. Returns in the first post-accept cycle.
  task automatic issue(input logic [1:0] op, input logic [2:0] dst,
                       input logic [2:0] src, input logic [7:0] imm);
    chk("ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op; bus.cmd_dst = dst; bus.cmd_src = src; bus.cmd_imm = imm;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_op = ~op; bus.cmd_dst = ~dst; bus.cmd_src = ~src; bus.cmd_imm = ~imm;
  endtask

  initial begin
    rst = 1'b1;
    ld_en = 1'b0; ld_sel = 3'd0; ld_val = 8'd0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_dst = 3'd0;
    bus.cmd_src = 3'd0; bus.cmd_imm = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_wr_en", bus.rf_wr_en, 0);
    chk("rst_rd_en", bus.rf_rd_en, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", bus.cmd_ready, 1);

    // LDI A <- 5A
    issue(2'b01, 3'b111, 3'd0, 8'h5A);
    chk("ldi_wr_en", bus.rf_wr_en, 1);
    chk("ldi_wr_sel", bus.rf_wr_sel, 3'b111);
    chk("ldi_wr_data", bus.rf_wr_data, 8'h5A);
    chk("ldi_done", bus.done, 1);
    chk("ldi_err", bus.err, 0);
    step();
    chk("ldi_ready", bus.cmd_ready, 1);
    chk("ldi_done_pulse", bus.done, 0);
    chk("ldi_A", rf[7], 8'h5A);

    // MOV E <- B (3C)
    load(3'd0, 8'h3C);
    issue(2'b00, 3'b011, 3'b000, 8'd0);
    chk("mov_rd_en", bus.rf_rd_en, 1);
    chk("mov_rd_sel", bus.rf_rd_sel, 3'b000);
    chk("mov_rd_done", bus.done, 0);
    step();
    chk("mov_wr_en", bus.rf_wr_en, 1);
    chk("mov_wr_sel", bus.rf_wr_sel, 3'b011);
    chk("mov_wr_data", bus.rf_wr_data, 8'h3C);
    chk("mov_done", bus.done, 1);
    chk("mov_err", bus.err, 0);
    step();
    chk("mov_E", rf[3], 8'h3C);

    // INC16 HL, H=12 L=FF; an LDI offered while busy must be ignored
    load(3'd4, 8'h12);
    load(3'd5, 8'hFF);
    issue(2'b10, 3'b100, 3'd0, 8'd0);
    chk("inc_rdlo_sel", bus.rf_rd_sel, 3'd5);
    chk("inc_rdlo_en", bus.rf_rd_en, 1);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_dst = 3'b111; bus.cmd_imm = 8'h77;
    step();
    bus.cmd_valid = 1'b0;
    chk("inc_wrlo_sel", bus.rf_wr_sel, 3'd5);
    chk("inc_wrlo_data", bus.rf_wr_data, 8'h00);
    chk("inc_wrlo_done", bus.done, 0);
    step();
    chk("inc_rdhi_sel", bus.rf_rd_sel, 3'd4);
    chk("inc_rdhi_wr_sel", bus.rf_wr_sel, 3'd0);
    step();
    chk("inc_wrhi_sel", bus.rf_wr_sel, 3'd4);
    chk("inc_wrhi_data", bus.rf_wr_data, 8'h13);
    chk("inc_done", bus.done, 1);
    step();
    chk("inc_L", rf[5], 8'h00);
    chk("inc_H", rf[4], 8'h13);
    chk("busy_ignore_A", rf[7], 8'h5A);

    // DEC16 BC = 0000 -> FFFF
    load(3'd0, 8'h00);
    load(3'd1, 8'h00);
    issue(2'b11, 3'b000, 3'd0, 8'd0);
    step();
    chk("dec_wrlo_sel", bus.rf_wr_sel, 3'd1);
    chk("dec_wrlo_data", bus.rf_wr_data, 8'hFF);
    step();
    step();
    chk("dec_wrhi_sel", bus.rf_wr_sel, 3'd0);
    chk("dec_wrhi_data", bus.rf_wr_data, 8'hFF);
    chk("dec_done", bus.done, 1);
    step();
    chk("dec_C", rf[1], 8'hFF);
    chk("dec_B", rf[0], 8'hFF);

    // INC16 DE = FFFF -> 0000
    load(3'd2, 8'hFF);
    load(3'd3, 8'hFF);
    issue(2'b10, 3'b010, 3'd0, 8'd0);
    step();
    chk("incde_wrlo_data", bus.rf_wr_data, 8'h00);
    step();
    step();
    chk("incde_wrhi_sel", bus.rf_wr_sel, 3'd2);
    chk("incde_wrhi_data", bus.rf_wr_data, 8'h00);
    step();
    chk("incde_D", rf[2], 8'h00);
    chk("incde_E", rf[3], 8'h00);

    // LDI to 110 rejected, then a back-to-back LDI C <- A5
    issue(2'b01, 3'b110, 3'd0, 8'h99);
    chk("err_done", bus.done, 1);
    chk("err_err", bus.err, 1);
    chk("err_wr_en", bus.rf_wr_en, 0);
    step();
    chk("err_ready", bus.cmd_ready, 1);
    chk("err_clear", bus.err, 0);
    chk("err_wr_en2", bus.rf_wr_en, 0);
    issue(2'b01, 3'b001, 3'd0, 8'hA5);
    chk("b2b_wr_en", bus.rf_wr_en, 1);
    chk("b2b_wr_sel", bus.rf_wr_sel, 3'd1);
    chk("b2b_wr_data", bus.rf_wr_data, 8'hA5);
    step();
    chk("b2b_C", rf[1], 8'hA5);

    // MOV from 110 and INC16 on pair 11 are rejected
    issue(2'b00, 3'b000, 3'b110, 8'd0);
    chk("errmov_err", bus.err, 1);
    chk("errmov_rd_en", bus.rf_rd_en, 0);
    step();
    issue(2'b10, 3'b110, 3'd0, 8'd0);
    chk("errinc_err", bus.err, 1);
    chk("errinc_rd_en", bus.rf_rd_en, 0);
    step();
    chk("err_B_kept", rf[0], 8'hFF);

    // MOV D <- D leaves the value in place
    load(3'd2, 8'h44);
    issue(2'b00, 3'b010, 3'b010, 8'd0);
    chk("movself_rd_sel", bus.rf_rd_sel, 3'd2);
    step();
    chk("movself_wr_data", bus.rf_wr_data, 8'h44);
    chk("movself_wr_sel", bus.rf_wr_sel, 3'd2);
    step();
    chk("movself_D", rf[2], 8'h44);

    // Reset during RD_HI of INC16 HL, L=FF
    load(3'd4, 8'h20);
    load(3'd5, 8'hFF);
    issue(2'b10, 3'b100, 3'd0, 8'd0);
    step();
    chk("rstmid_wrlo_data", bus.rf_wr_data, 8'h00);
    step();
    chk("rstmid_rdhi_en", bus.rf_rd_en, 1);
    rst = 1'b1;
    step();
    chk("rstmid_wr_en", bus.rf_wr_en, 0);
    chk("rstmid_rd_en", bus.rf_rd_en, 0);
    chk("rstmid_wr_sel", bus.rf_wr_sel, 0);
    chk("rstmid_wr_data", bus.rf_wr_data, 0);
    chk("rstmid_done", bus.done, 0);
    rst = 1'b0;
    step();
    chk("rstmid_ready", bus.cmd_ready, 1);
    chk("rstmid_wr_en2", bus.rf_wr_en, 0);
    chk("rstmid_L", rf[5], 8'h00);
    chk("rstmid_H", rf[4], 8'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_seq.md
REGFILE_SEQ -- requirements
Module: regfile_seq

Interface
REQ-001 SHALL have parameter OP_W, default 2, width of cmd_op.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port cmd_valid  in  1  command offered.
REQ-005 SHALL have port cmd_ready  out  1  block can accept a command (high only in IDLE).
REQ-006 SHALL have port cmd_op  in  OP_W  opcode: 00 MOV, 01 LDI, 10 INC16, 11 DEC16.
REQ-007 SHALL have port cmd_dst  in  3  destination register code (A=111, B=000, C=001, D=010, E=011, H=100, L=101); for INC16/DEC16, bits [2:1] are the pair (00 BC, 01 DE, 10 HL).
REQ-008 SHALL have port cmd_src  in  3  MOV source register code.
REQ-009 SHALL have port cmd_imm  in  8  LDI immediate.
REQ-010 SHALL have ports rf_rd_sel out 3, rf_rd_en out 1, rf_rd_data in 8: register-file read port; read is combinational.
REQ-011 SHALL have ports rf_wr_sel out 3, rf_wr_en out 1, rf_wr_data out 8: register-file write port; the write commits on the clk edge that ends the cycle with rf_wr_en high.
REQ-012 SHALL have port busy  out  1  command in progress (= ~cmd_ready).
REQ-013 SHALL have port done  out  1  one-cycle completion pulse.
REQ-014 SHALL have port err  out  1  qualifies done: command rejected, no write performed.

Function
REQ-015 SHALL accept a command on the clk edge where cmd_valid && cmd_ready, latching op, dst, src and imm; later changes to cmd_* SHALL NOT affect that command.
REQ-016 SHALL implement states IDLE, LDI_WR, MOV_RD, MOV_WR, RD_LO, WR_LO, RD_HI, WR_HI, ERR.
REQ-017 SHALL follow these transitions: IDLE->LDI_WR (LDI); IDLE->MOV_RD->MOV_WR (MOV); IDLE->RD_LO->WR_LO->RD_HI->WR_HI (INC16/DEC16); LDI_WR, MOV_WR, WR_HI and ERR->IDLE.
REQ-018 SHALL go IDLE->ERR when the command is invalid: MOV/LDI dst=110, MOV src=110, or INC16/DEC16 pair=11.
REQ-019 SHALL in ERR assert done=1 and err=1 for one cycle, with no rf_wr_en.
REQ-020 SHALL in LDI_WR drive rf_wr_sel=dst, rf_wr_data=imm, rf_wr_en=1.
REQ-021 SHALL in MOV_RD drive rf_rd_sel=src, rf_rd_en=1, and capture rf_rd_data into an internal temp at the cycle end.
REQ-022 SHALL in MOV_WR drive rf_wr_sel=dst, rf_wr_data=temp, rf_wr_en=1.
REQ-023 SHALL use low register {pair,1} and high register {pair,0}.
REQ-024 SHALL in RD_LO read the low register and capture it into temp.
REQ-025 SHALL in WR_LO write the low register with temp+1 (INC16) or temp-1 (DEC16), modulo 256, and latch carry = (temp==FF) for INC16 or borrow = (temp==00) for DEC16.
REQ-026 SHALL in RD_HI read the high register and capture it into temp.
REQ-027 SHALL in WR_HI write the high register with temp+carry or temp-borrow, modulo 256, so FFFF wraps to 0000 and 0000 wraps to FFFF.
REQ-028 SHALL assert done=1, err=0 in the final write cycle (LDI_WR, MOV_WR, WR_HI).
REQ-029 SHALL give completion latency from the accept edge of 1 cycle (LDI, ERR), 2 cycles (MOV) and 4 cycles (INC16/DEC16).
REQ-030 SHALL return cmd_ready high the cycle after done, allowing back-to-back commands with no extra bubble.
REQ-031 SHALL drive rf_rd_en=1 only in read states and rf_wr_en=1 only in write states; never both in one cycle.
REQ-032 SHALL drive selects and rf_wr_data to 0 when the corresponding enable is low.
REQ-033 SHALL never touch flags; INC16/DEC16 are flag-neutral.
REQ-034 SHALL for MOV with src==dst perform the read and write normally, leaving the value unchanged.
REQ-035 SHALL ignore cmd_valid while busy.

Reset
REQ-036 SHALL, when rst is high at a clk edge, go to IDLE and clear temp, carry, done, err, and all rf_* enables, selects and data to 0; cmd_ready SHALL be 1 the cycle after reset deasserts.
REQ-037 SHALL abort a command with no write when rst rises mid-command; writes committed before the reset edge remain, so INC16 may leave only the low byte updated.

Verification
REQ-038 SHALL pass: LDI dst=111 imm=5A -> one cycle later rf_wr_en=1, sel=111, data=5A; done=1, err=0.
REQ-039 SHALL pass: MOV src=000 (B=3C), dst=011 -> MOV_RD rd_sel=000; next cycle wr_sel=011, data=3C, done.
REQ-040 SHALL pass: INC16 pair HL with H=12, L=FF -> L written 00, H written 13; done on the 4th cycle.
REQ-041 SHALL pass: DEC16 pair BC=0000 -> C=FF, B=FF; INC16 DE=FFFF -> 0000.
REQ-042 SHALL pass: LDI dst=110 -> done=err=1 the next cycle, no rf_wr_en at any point; cmd_ready high the cycle after.
REQ-043 SHALL pass: rst asserted during RD_HI of INC16 on L=FF -> no further write, outputs zero, IDLE; L=00, H unchanged.
